// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU and its program sequencer.
package cpu_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned LEN_W  = ADDR_W + 1;

   // CPU opcodes, carried in instr[7:5]
   typedef enum logic [OP_W-1:0] {
      OP_HLT = 3'b000,
      OP_SKZ = 3'b001,
      OP_ADD = 3'b010,
      OP_AND = 3'b011,
      OP_XOR = 3'b100,
      OP_LDA = 3'b101,
      OP_STO = 3'b110,
      OP_JMP = 3'b111
   } opcode_e;

   // Sequencer control states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } seq_state_e;

   // Termination cause reported in DONE
   typedef enum logic [1:0] {
      STAT_NONE    = 2'b00,
      STAT_HALTED  = 2'b01,
      STAT_TIMEOUT = 2'b10,
      STAT_ABORTED = 2'b11
   } seq_status_e;

   // Instruction byte layout
   typedef struct packed {
      opcode_e           opcode;
      logic [ADDR_W-1:0] addr;
   } instr_t;

   // True when the instruction byte decodes to HLT
   function automatic logic is_halt(input logic [DATA_W-1:0] instr);
      instr_t ins;
      ins = instr_t'(instr);
      return ins.opcode == OP_HLT;
   endfunction

endpackage

// File: rtl/seq_instr_store.sv
// Instruction store: synchronous write, combinational read, cleared by reset.
module seq_instr_store
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage array with asynchronous clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cpu_program_sequencer.sv
// Program loader and run controller for the 8-bit accumulator CPU.
module cpu_program_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned MAX_CYCLES = 1024,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_req,
   input  logic              host_valid,
   input  logic [DATA_W-1:0] host_data,
   input  logic              host_last,
   output logic              host_ready,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] cpu_pc,
   input  logic [DATA_W-1:0] cpu_instr,
   output logic              cpu_load,
   output logic [DATA_W-1:0] cpu_data,
   output logic              busy,
   output logic              done,
   output logic [1:0]        status,
   output logic              overflow,
   output logic [LEN_W-1:0]  prog_len,
   output logic [ADDR_W-1:0] halt_pc,
   output logic [CNT_W-1:0]  cycle_count
);

   seq_state_e        state_q, state_d;
   logic [LEN_W-1:0]  prog_len_d;
   logic              overflow_d;
   logic [1:0]        status_d;
   logic [ADDR_W-1:0] halt_pc_d;
   logic [CNT_W-1:0]  cycle_count_d;
   logic              wr_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              cpu_halted;

   // Only the opcode field of the CPU instruction register matters here
   logic unused_instr_bits;
   assign unused_instr_bits = ^cpu_instr[ADDR_W-1:0];
   assign cpu_halted        = is_halt(cpu_instr);

   // The write pointer is the running byte count, so prog_len addresses the store
   seq_instr_store #(.DEPTH(DEPTH)) u_store (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (prog_len[ADDR_W-1:0]),
      .wr_data (host_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // State and status registers; handshake/status flags registered from next state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         prog_len    <= '0;
         overflow    <= 1'b0;
         status      <= STAT_NONE;
         halt_pc     <= '0;
         cycle_count <= '0;
         host_ready  <= 1'b0;
         cpu_load    <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         prog_len    <= prog_len_d;
         overflow    <= overflow_d;
         status      <= status_d;
         halt_pc     <= halt_pc_d;
         cycle_count <= cycle_count_d;
         host_ready  <= (state_d == ST_LOAD);
         cpu_load    <= (state_d != ST_RUN);
         busy        <= (state_d == ST_LOAD) || (state_d == ST_RUN);
         done        <= (state_d == ST_DONE);
      end
   end

   // Next-state, store write and counter update
   always_comb begin
      state_d       = state_q;
      prog_len_d    = prog_len;
      overflow_d    = overflow;
      status_d      = status;
      halt_pc_d     = halt_pc;
      cycle_count_d = cycle_count;
      wr_en         = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (load_req) begin
               state_d    = ST_LOAD;
               prog_len_d = '0;
               overflow_d = 1'b0;
            end else if (start && (prog_len != '0)) begin
               state_d       = ST_RUN;
               cycle_count_d = '0;
               status_d      = STAT_NONE;
            end
         end

         ST_LOAD: begin
            if (host_valid) begin
               if (prog_len < LEN_W'(DEPTH)) begin
                  wr_en      = 1'b1;
                  prog_len_d = prog_len + LEN_W'(1);
               end else begin
                  overflow_d = 1'b1;
               end
               if (host_last) begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_RUN: begin
            if (!(&cycle_count)) begin
               cycle_count_d = cycle_count + CNT_W'(1);
            end
            // First RUN cycle skips the halt test: the CPU IR still holds the prefetch
            if (abort) begin
               state_d   = ST_DONE;
               status_d  = STAT_ABORTED;
               halt_pc_d = cpu_pc;
            end else if ((cycle_count != '0) && cpu_halted) begin
               state_d   = ST_DONE;
               status_d  = STAT_HALTED;
               halt_pc_d = cpu_pc;
            end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
               state_d   = ST_DONE;
               status_d  = STAT_TIMEOUT;
               halt_pc_d = cpu_pc;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // CPU fetch path: PC-indexed in RUN with HLT past the program, else prefetch entry 0
   always_comb begin
      rd_addr  = '0;
      cpu_data = rd_data;
      if (state_q == ST_RUN) begin
         rd_addr = cpu_pc;
         if (LEN_W'(cpu_pc) >= prog_len) begin
            cpu_data = '0;
         end
      end
   end

endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Self-checking bench for cpu_program_sequencer with a small CPU stand-in.
module tb_cpu_program_sequencer;

   localparam int MAXC = 64;

   logic        clock = 1'b0;
   logic        reset;
   logic        load_req, host_valid, host_last, start, abort;
   logic [7:0]  host_data;
   logic        host_ready, cpu_load, busy, done, overflow;
   logic [4:0]  cpu_pc, halt_pc;
   logic [7:0]  cpu_instr, cpu_data;
   logic [1:0]  status;
   logic [5:0]  prog_len;
   logic [15:0] cycle_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] prog [0:32];

   // CPU stand-in: PC and instruction register, or direct drive in manual mode
   logic       manual;
   logic [4:0] m_pc, stub_pc;
   logic [7:0] m_ir, stub_ir;

   always #5 clock = ~clock;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         stub_pc <= '0;
         stub_ir <= '0;
      end else if (cpu_load) begin
         stub_pc <= '0;
         stub_ir <= cpu_data;
      end else begin
         stub_ir <= cpu_data;
         if (cpu_data[7:5] == 3'b111) stub_pc <= cpu_data[4:0];
         else if (cpu_data[7:5] != 3'b000) stub_pc <= stub_pc + 5'd1;
      end
   end

   assign cpu_pc    = manual ? m_pc : stub_pc;
   assign cpu_instr = manual ? m_ir : stub_ir;

   cpu_program_sequencer #(.DEPTH(32), .MAX_CYCLES(MAXC), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .load_req(load_req), .host_valid(host_valid),
      .host_data(host_data), .host_last(host_last), .host_ready(host_ready),
      .start(start), .abort(abort), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr),
      .cpu_load(cpu_load), .cpu_data(cpu_data), .busy(busy), .done(done),
      .status(status), .overflow(overflow), .prog_len(prog_len),
      .halt_pc(halt_pc), .cycle_count(cycle_count)
   );

   // Program-level prediction: walk the program trace until abort, halt or cycle limit
   task automatic model_run(input int len, input int abort_at,
                            output logic [1:0] st, output int cnt, output logic [4:0] hpc);
      logic [4:0] pc;
      logic [7:0] ir, d;
      pc = 5'd0; ir = prog[0]; st = 2'b00; cnt = 0; hpc = 5'd0;
      for (int k = 0; k < MAXC; k++) begin
         d = (int'(pc) < len) ? prog[pc] : 8'h00;
         if (k == abort_at) begin st = 2'b11; cnt = k + 1; hpc = pc; return; end
         if (k >= 1 && ir[7:5] == 3'b000) begin st = 2'b01; cnt = k + 1; hpc = pc; return; end
         if (k == MAXC - 1) begin st = 2'b10; cnt = k + 1; hpc = pc; return; end
         ir = d;
         if (d[7:5] == 3'b111) pc = d[4:0];
         else if (d[7:5] != 3'b000) pc = pc + 5'd1;
      end
   endtask

   // Stream prog[0..n-1] to the host port, optionally entering LOAD first
   task automatic load_prog(input int n, input bit do_req, input bit gaps);
      int g;
      if (do_req) begin
         load_req = 1'b1; @(posedge clock); #1; load_req = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         host_valid = 1'b0; host_last = 1'b0;
         g = gaps ? int'($urandom_range(0, 2)) : 0;
         repeat (g) begin @(posedge clock); #1; end
         host_valid = 1'b1; host_data = prog[i]; host_last = (i == n - 1);
         @(posedge clock); #1;
      end
      host_valid = 1'b0; host_last = 1'b0;
   endtask

   // Pulse start, optionally abort at a RUN cycle, and count RUN cycles until done
   task automatic run_prog(input int abort_at, output int ncyc);
      ncyc = 0;
      start = 1'b1; @(posedge clock); #1; start = 1'b0;
      for (int k = 0; k < 200; k++) begin
         abort = (k == abort_at);
         n_checks++;
         if ({busy, cpu_load, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL run_flags cycle %0d: busy/cpu_load/done=%b required 100", k, {busy, cpu_load, done});
         end
         @(posedge clock); #1;
         abort = 1'b0;
         ncyc = k + 1;
         if (done === 1'b1) break;
      end
      n_checks++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL run_end: done=%b required 1 within bound", done); end
   endtask

   task automatic test_reset();
      n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL rst_host_ready: got %b required 0", host_ready); end
      n_checks++; if (cpu_load !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_load: got %b required 1", cpu_load); end
      n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL rst_busy_done: got %b required 00", {busy, done}); end
      n_checks++; if (prog_len !== 6'd0) begin n_fail++; $display("FAIL rst_prog_len: got %0d required 0", prog_len); end
      n_checks++; if ({overflow, status} !== 3'b000) begin n_fail++; $display("FAIL rst_ovf_status: got %b required 000", {overflow, status}); end
      n_checks++; if (halt_pc !== 5'd0 || cycle_count !== 16'd0) begin n_fail++; $display("FAIL rst_pc_count: got %0d/%0d required 0/0", halt_pc, cycle_count); end
      n_checks++; if (cpu_data !== 8'h00) begin n_fail++; $display("FAIL rst_cpu_data: got %h required 00", cpu_data); end
   endtask

   task automatic test_start_empty();
      start = 1'b1; @(posedge clock); #1; start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if ({cpu_load, busy, done, host_ready} !== 4'b1000) begin
            n_fail++; $display("FAIL empty_start cycle %0d: cpu_load/busy/done/ready=%b required 1000", i, {cpu_load, busy, done, host_ready});
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_halt_program();
      int nc;
      prog[0] = 8'hBB; prog[1] = 8'h00;
      load_prog(2, 1'b1, 1'b0);
      n_checks++; if (prog_len !== 6'd2 || overflow !== 1'b0) begin n_fail++; $display("FAIL halt_load: len/ovf=%0d/%b required 2/0", prog_len, overflow); end
      @(posedge clock); #1;
      run_prog(-1, nc);
      n_checks++; if (nc > 6) begin n_fail++; $display("FAIL halt_latency: %0d cycles required <= 6", nc); end
      n_checks++; if (status !== 2'b01) begin n_fail++; $display("FAIL halt_status: got %b required 01", status); end
      n_checks++; if (cycle_count !== 16'd3 || halt_pc !== 5'd1) begin n_fail++; $display("FAIL halt_count_pc: got %0d/%0d required 3/1", cycle_count, halt_pc); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 33; i++) prog[i] = {3'b101, 5'(i)};
      load_prog(33, 1'b1, 1'b0);
      n_checks++; if (prog_len !== 6'd32 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_len: len/ovf=%0d/%b required 32/1", prog_len, overflow); end
      n_checks++; if ({host_ready, busy, done} !== 3'b000) begin n_fail++; $display("FAIL ovf_idle: ready/busy/done=%b required 000", {host_ready, busy, done}); end
      n_checks++; if (cpu_data !== 8'hA0) begin n_fail++; $display("FAIL ovf_prefetch: got %h required a0", cpu_data); end
      manual = 1'b1; m_pc = 5'd0; m_ir = 8'hA0;
      start = 1'b1; @(posedge clock); #1; start = 1'b0;
      m_pc = 5'd31; #1;
      n_checks++; if (cpu_data !== 8'hBF) begin n_fail++; $display("FAIL ovf_store31: got %h required bf", cpu_data); end
      m_pc = 5'd5; #1;
      n_checks++; if (cpu_data !== 8'hA5) begin n_fail++; $display("FAIL ovf_store5: got %h required a5", cpu_data); end
      abort = 1'b1; @(posedge clock); #1; abort = 1'b0;
      n_checks++; if ({done, status} !== 3'b111 || halt_pc !== 5'd5 || cycle_count !== 16'd1) begin
         n_fail++; $display("FAIL ovf_abort: done/status=%b pc=%0d cnt=%0d required 111/5/1", {done, status}, halt_pc, cycle_count);
      end
      manual = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_timeout();
      int nc;
      prog[0] = 8'hE0;
      load_prog(1, 1'b1, 1'b0);
      @(posedge clock); #1;
      run_prog(-1, nc);
      n_checks++; if (status !== 2'b10) begin n_fail++; $display("FAIL to_status: got %b required 10", status); end
      n_checks++; if (cycle_count !== 16'd64 || nc != 64) begin n_fail++; $display("FAIL to_count: got %0d (%0d cycles) required 64", cycle_count, nc); end
      n_checks++; if ({cpu_load, busy, done} !== 3'b101) begin n_fail++; $display("FAIL to_flags: cpu_load/busy/done=%b required 101", {cpu_load, busy, done}); end
   endtask

   task automatic test_abort_rerun();
      int nc;
      run_prog(5, nc);
      n_checks++; if (status !== 2'b11 || cycle_count !== 16'd6) begin n_fail++; $display("FAIL ab_status: status/cnt=%b/%0d required 11/6", status, cycle_count); end
      n_checks++; if (halt_pc !== 5'd0) begin n_fail++; $display("FAIL ab_pc: got %0d required 0", halt_pc); end
      start = 1'b1; @(posedge clock); #1; start = 1'b0;
      n_checks++; if (cycle_count !== 16'd0 || busy !== 1'b1 || status !== 2'b00) begin n_fail++; $display("FAIL rerun_clear: cnt/busy/status=%0d/%b/%b required 0/1/00", cycle_count, busy, status); end
      @(posedge clock); #1;
      n_checks++; if (cycle_count !== 16'd1) begin n_fail++; $display("FAIL rerun_count: got %0d required 1", cycle_count); end
      abort = 1'b1; @(posedge clock); #1; abort = 1'b0;
      n_checks++; if ({done, status} !== 3'b111 || cycle_count !== 16'd2) begin n_fail++; $display("FAIL rerun_abort: done/status=%b cnt=%0d required 111/2", {done, status}, cycle_count); end
   endtask

   task automatic test_load_priority();
      load_req = 1'b1; start = 1'b1; @(posedge clock); #1; load_req = 1'b0; start = 1'b0;
      n_checks++; if ({host_ready, busy, done, cpu_load} !== 4'b1101 || prog_len !== 6'd0) begin
         n_fail++; $display("FAIL prio_load: ready/busy/done/load=%b len=%0d required 1101/0", {host_ready, busy, done, cpu_load}, prog_len);
      end
      start = 1'b1; abort = 1'b1; @(posedge clock); #1; start = 1'b0; abort = 1'b0;
      n_checks++; if ({host_ready, busy, cpu_load} !== 3'b111) begin n_fail++; $display("FAIL load_ignores: ready/busy/load=%b required 111", {host_ready, busy, cpu_load}); end
      prog[0] = 8'hA3; prog[1] = 8'h00;
      load_prog(2, 1'b0, 1'b1);
      n_checks++; if (prog_len !== 6'd2 || host_ready !== 1'b0) begin n_fail++; $display("FAIL prio_done: len/ready=%0d/%b required 2/0", prog_len, host_ready); end
   endtask

   task automatic test_random();
      int len, ab, nc, ecnt;
      logic [2:0] op;
      logic [4:0] ad, epc;
      logic [1:0] est;
      for (int it = 0; it < 25; it++) begin
         len = int'($urandom_range(1, 32));
         for (int i = 0; i < len; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8) op = 3'b000;
            else if (r < 20) op = 3'b111;
            else op = 3'($urandom_range(1, 6));
            ad = (op == 3'b111) ? 5'($urandom_range(0, len)) : 5'($urandom_range(0, 31));
            prog[i] = {op, ad};
         end
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
         model_run(len, ab, est, ecnt, epc);
         load_prog(len, 1'b1, 1'b1);
         n_checks++; if (prog_len !== 6'(len) || overflow !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_len: len/ovf=%0d/%b required %0d/0", it, prog_len, overflow, len); end
         @(posedge clock); #1;
         run_prog(ab, nc);
         n_checks++; if (status !== est) begin n_fail++; $display("FAIL rnd%0d_status: got %b required %b", it, status, est); end
         n_checks++; if (int'(cycle_count) != ecnt || halt_pc !== epc) begin n_fail++; $display("FAIL rnd%0d_cnt_pc: got %0d/%0d required %0d/%0d", it, cycle_count, halt_pc, ecnt, epc); end
      end
   endtask

   task automatic test_reset_mid_load();
      prog[0] = 8'hA1; prog[1] = 8'hA2; prog[2] = 8'hA3;
      load_req = 1'b1; @(posedge clock); #1; load_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         host_valid = 1'b1; host_data = prog[i]; @(posedge clock); #1;
      end
      #2 reset = 1'b1;
      #1;
      n_checks++; if ({host_ready, cpu_load, busy, done} !== 4'b0100) begin n_fail++; $display("FAIL mid_rst_flags: ready/load/busy/done=%b required 0100", {host_ready, cpu_load, busy, done}); end
      n_checks++; if (prog_len !== 6'd0 || cpu_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_store: len=%0d data=%h required 0/00", prog_len, cpu_data); end
      host_valid = 1'b0;
      #2 reset = 1'b0;
      @(posedge clock); #1;
      n_checks++; if ({host_ready, busy, done} !== 3'b000 || cpu_data !== 8'h00) begin n_fail++; $display("FAIL post_rst_idle: ready/busy/done=%b data=%h required 000/00", {host_ready, busy, done}, cpu_data); end
   endtask

   initial begin
      reset = 1'b1; load_req = 1'b0; host_valid = 1'b0; host_last = 1'b0; host_data = 8'h00;
      start = 1'b0; abort = 1'b0; manual = 1'b0; m_pc = 5'd0; m_ir = 8'h00;
      #23 reset = 1'b0;
      @(posedge clock); #1;
      test_reset();
      test_start_empty();
      test_halt_program();
      test_overflow();
      test_timeout();
      test_abort_rerun();
      test_load_priority();
      test_random();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_program_sequencer.md
Name: cpu_program_sequencer

Overview:
Front-end controller for the 8-bit accumulator CPU. Accepts a program byte stream from a host over a valid/ready handshake and buffers it in a local 32-entry instruction store. On start, releases the CPU from Load and feeds the CPU's data_in from the store, indexed by the CPU program counter. Detects HLT, watchdog timeout or host abort, then parks the CPU back in Load and reports status.

Parameters:
DEPTH, 32, instruction store entries; must equal the CPU address space (2^5).
MAX_CYCLES, 1024, RUN-state cycle limit before timeout; range 2..65535.
CNT_W, 16, width of cycle_count.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
load_req  in  1  pulse; enter LOAD from IDLE or DONE
host_valid  in  1  host byte valid
host_data  in  8  program byte {opcode[2:0], addr[4:0]}
host_last  in  1  marks final byte of program
host_ready  out  1  sequencer accepts a byte this cycle
start  in  1  pulse; begin execution from IDLE
abort  in  1  force stop during RUN
cpu_pc  in  5  CPU Program_counter output
cpu_instr  in  8  CPU Instruction output (registered opcode/addr)
cpu_load  out  1  drives CPU Load; holds the CPU PC at 0
cpu_data  out  8  drives CPU data_in
busy  out  1  state is LOAD or RUN
done  out  1  state is DONE
status  out  2  00 none, 01 halted, 10 timeout, 11 aborted; valid in DONE
overflow  out  1  sticky; more than DEPTH bytes offered in the last load
prog_len  out  6  bytes stored by the last load, 0..32
halt_pc  out  5  cpu_pc captured at termination
cycle_count  out  CNT_W  RUN cycles of the last run, saturating

Behaviour:
- Reset values: state IDLE; all store entries 8'h00; prog_len 0; overflow 0; status 00; halt_pc 0; cycle_count 0; host_ready 0; cpu_load 1; busy 0; done 0.
- States:
  - IDLE:
    - load_req -> LOAD: clears prog_len, overflow and the write pointer.
    - start with prog_len>0 -> RUN: clears cycle_count and status.
    - start with prog_len==0 is ignored and IDLE is held.
    - If load_req and start arrive together, load_req wins.
  - LOAD:
    - host_ready=1.
    - On host_valid&host_ready the byte is written to store[wr_ptr].
    - If wr_ptr<DEPTH, wr_ptr and prog_len both increment.
    - At wr_ptr==DEPTH the byte is dropped and overflow is set; the sequencer stays in LOAD.
    - An accepted byte with host_last -> IDLE on the next edge; that byte obeys the same write/drop rule.
    - start and abort are ignored in LOAD.
  - RUN:
    - cpu_load=0; cycle_count increments each cycle and saturates at all-ones.
    - Exit checks are evaluated each cycle in priority order: abort, then halt, then timeout.
    - abort -> DONE with status 11.
    - Halt: cycle_count>=1 and cpu_instr[7:5]==3'b000 -> DONE with status 01. The first RUN cycle is excluded because the CPU instruction register still holds the pre-start byte.
    - Timeout: cycle_count==MAX_CYCLES-1 -> DONE with status 10.
    - On exit, halt_pc is loaded with cpu_pc.
  - DONE:
    - cpu_load=1; status, halt_pc and cycle_count are held.
    - load_req -> LOAD.
    - start with prog_len>0 -> RUN (re-run of the same program).
- cpu_load = 1 in every state except RUN. This holds the CPU PC at 0 and resynchronises its control on release.
- cpu_data:
  - In RUN: store[cpu_pc] when cpu_pc<prog_len, else 8'h00 (HLT). Running past the loaded program therefore halts.
  - Outside RUN: store[0] (prefetch), so the CPU instruction register already holds the first instruction at release.
- cpu_data is combinational from cpu_pc (zero-latency read). Store writes are synchronous.
- Store contents persist across runs and are cleared only by reset. Stale entries at or beyond prog_len are masked by the prog_len compare.
- Reset mid-LOAD or mid-RUN: the asynchronous reset returns to IDLE immediately with the reset values above; cpu_load rises the same instant.
- busy = (LOAD|RUN); done = DONE. Both are decoded from registered state, so they are glitch-free.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111;
  - state encoding for IDLE/LOAD/RUN/DONE;
  - status codes.
- One sub-module, seq_instr_store: DEPTH x 8 array, async reset to 0, one synchronous write port, one combinational read port.
- The FSM, counters and cpu_data mux stay in the top.

Test Plan:
- Load {8'hBB (LDA 1B), 8'h00}, host_last on byte 2, then pulse start -> prog_len=2, busy during RUN, done within 6 cycles, status=01, overflow=0.
- Offer 33 bytes with host_last on the 33rd -> prog_len=32, overflow=1, store[31] = byte 32, state returns to IDLE.
- MAX_CYCLES=64, program {8'hE0 (JMP 0)}, start -> status=10, cycle_count=64, cpu_load=1 in DONE.
- start with prog_len=0 after reset -> stays IDLE, cpu_load=1, busy=0 for 10 cycles.
- Abort at RUN cycle 5 of a JMP loop -> status=11, cycle_count=6, halt_pc = cpu_pc sampled that cycle; a second start re-runs and counting restarts from 0.
- Assert reset mid-LOAD after 3 bytes -> prog_len=0, host_ready=0, store reads 8'h00, state IDLE.
